hazard_ctrl: RTL
================

Name: hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage RV32 pipeline (IF/ID/EXE/MEM/WB).
- Detects load-use hazards and sequences branch/jump flush bubbles.
- Applies memory-stall freeze, with freeze taking priority over all other actions.
- Drives the hold/flush inputs of the PC, IF/ID and ID/EXE registers, and owns the architectural cycle/instret counters, so the pipeline registers carry no counting logic.

Parameters:
- FLUSH_CYCLES, 2: ID-side bubbles inserted after a taken branch/jump resolves in EXE; legal range 1..7.
- CNT_W, 64: width of the cycle and instret counters.

Ports:
- clk  input  1  clock
- reset  input  1  reset, asynchronous, active-low
- id_rs1_addr  input  5  rs1 of the instruction in ID
- id_rs2_addr  input  5  rs2 of the instruction in ID
- id_uses_rs1  input  1  ID instruction reads rs1
- id_uses_rs2  input  1  ID instruction reads rs2
- exe_rd_addr  input  5  rd of the instruction in EXE
- exe_mem_read  input  1  EXE instruction is a load
- exe_branch_taken  input  1  EXE resolved a taken branch or jump this cycle
- im_stall  input  1  instruction memory not ready
- dm_stall  input  1  data memory not ready
- wb_valid  input  1  a real (non-bubble) instruction is in WB
- pipe_freeze  output  1  hold every pipeline register
- pc_hold  output  1  PC keeps its value
- ifid_hold  output  1  IF/ID keeps its value
- ifid_flush  output  1  IF/ID loads a bubble
- idexe_flush  output  1  ID/EXE control bits cleared (bubble)
- flush_busy  output  1  FSM is in BR_FLUSH
- cycle_cnt  output  CNT_W  cycles since reset
- instret_cnt  output  CNT_W  retired instructions
- lu_stall_cnt  output  32  load-use bubbles inserted (optional feature)
- br_flush_cnt  output  32  taken-branch flush events (optional feature)

Behaviour:
- Reset (async, reset=0):
  - state=RUN, flush counter=0.
  - All counters=0.
  - All control outputs=0; combinational outputs evaluate to 0 when inputs are idle.
- pipe_freeze = im_stall | dm_stall (combinational).
- While frozen:
  - pc_hold=1, ifid_hold=1, ifid_flush=0, idexe_flush=0.
  - FSM state, flush counter and instret_cnt hold.
  - cycle_cnt still increments.
- Load-use hazard (lu):
  - lu = exe_mem_read & (exe_rd_addr!=0) & ((id_uses_rs1 & id_rs1_addr==exe_rd_addr) | (id_uses_rs2 & id_rs2_addr==exe_rd_addr)).
- FSM states: RUN, BR_FLUSH. Unfrozen outputs are combinational from state and inputs.
- RUN, exe_branch_taken=1:
  - ifid_flush=1, idexe_flush=1, pc_hold=0. Branch wins over a simultaneous lu; no stall is taken.
  - If FLUSH_CYCLES>1: load flush counter with FLUSH_CYCLES-1 and go to BR_FLUSH. Otherwise stay in RUN.
- RUN, lu=1 and no taken branch:
  - pc_hold=1, ifid_hold=1, idexe_flush=1 for exactly this cycle.
  - Next cycle the load is in MEM and lu clears naturally; no state change.
- RUN, otherwise: all control outputs 0.
- BR_FLUSH:
  - ifid_flush=1, idexe_flush=1, flush_busy=1; lu is ignored.
  - Counter decrements each unfrozen cycle; on the cycle the counter equals 1, next state is RUN.
  - exe_branch_taken in BR_FLUSH is illegal because EXE holds a bubble; it is ignored and does not restart the count.
- Freeze arriving mid-BR_FLUSH suspends the count; it resumes unchanged after freeze drops.
- cycle_cnt:
  - +1 every clock after reset deassertion; wraps modulo 2^CNT_W.
- instret_cnt:
  - +1 when wb_valid & ~pipe_freeze; wraps modulo 2^CNT_W.
  - Counts each retired instruction exactly once, including during long stalls.
- Reset asserted mid-flush returns immediately to RUN with all outputs 0; no pending flush survives.

Optional Feature:
- Macro HAZARD_PERF_EN.
- Defined:
  - lu_stall_cnt +1 on each unfrozen cycle where the lu stall is applied.
  - br_flush_cnt +1 on each unfrozen RUN cycle with exe_branch_taken=1.
  - Both saturate at 32'hFFFF_FFFF and reset to 0.
- Not defined: both outputs tied to 32'h0 and no counter flops are synthesized.

Test Plan:
- Load-use, rs1 path: exe_mem_read=1, exe_rd_addr=5, id_uses_rs1=1, id_rs1_addr=5 for 1 cycle → pc_hold=ifid_hold=idexe_flush=1 that cycle only. Same stimulus with exe_rd_addr=0 → all 0.
- Taken branch, FLUSH_CYCLES=2: exe_branch_taken pulse at cycle N → ifid_flush=idexe_flush=1 at N and N+1; flush_busy=1 at N+1; RUN at N+2.
- Branch plus load-use in the same cycle → flush asserted, pc_hold=0, lu_stall_cnt unchanged, br_flush_cnt +1.
- dm_stall held 3 cycles during BR_FLUSH with wb_valid=1 → pipe_freeze=1 for 3 cycles, no flushes. instret_cnt unchanged during the 3 frozen cycles, then +1 on the first unfrozen cycle. Flush then completes with 1 remaining cycle. cycle_cnt +3.
- Retirement count: 10 consecutive wb_valid cycles unfrozen → instret_cnt=10. Preload cycle_cnt near 2^CNT_W-1 via force → wraps to 0.
- Reset pulse (reset=0 for 1 cycle) while in BR_FLUSH → state RUN, all counters 0, flush outputs 0 on the next edge.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32 pipeline, plus the cycle/instret counters.
// Define HAZARD_PERF_EN to build the saturating load-use / branch-flush event counters.
module hazard_ctrl #(
   parameter int FLUSH_CYCLES = 2,
   parameter int CNT_W        = 64
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       id_rs1_addr,
   input  logic [4:0]       id_rs2_addr,
   input  logic             id_uses_rs1,
   input  logic             id_uses_rs2,
   input  logic [4:0]       exe_rd_addr,
   input  logic             exe_mem_read,
   input  logic             exe_branch_taken,
   input  logic             im_stall,
   input  logic             dm_stall,
   input  logic             wb_valid,
   output logic             pipe_freeze,
   output logic             pc_hold,
   output logic             ifid_hold,
   output logic             ifid_flush,
   output logic             idexe_flush,
   output logic             flush_busy,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic [CNT_W-1:0] instret_cnt,
   output logic [31:0]      lu_stall_cnt,
   output logic [31:0]      br_flush_cnt
);

   typedef enum logic {RUN = 1'b0, BR_FLUSH = 1'b1} state_t;

   localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [2:0]       FLUSH_LD  = 3'(FLUSH_CYCLES - 1);

   state_t           r_state, w_state_nxt;
   logic [2:0]       r_flush_cnt, w_flush_cnt_nxt;
   logic [CNT_W-1:0] r_cycle_cnt, r_instret_cnt;
   logic             w_freeze, w_lu;

   assign w_freeze    = im_stall | dm_stall;
   assign pipe_freeze = w_freeze;
   assign flush_busy  = (r_state == BR_FLUSH);

   assign w_lu = exe_mem_read && (exe_rd_addr != 5'd0) &&
                 ((id_uses_rs1 && (id_rs1_addr == exe_rd_addr)) ||
                  (id_uses_rs2 && (id_rs2_addr == exe_rd_addr)));

   always_comb begin
      // NOTE: every output gets a default first so no path through the case infers a latch.
      w_state_nxt     = r_state;
      w_flush_cnt_nxt = r_flush_cnt;
      pc_hold         = 1'b0;
      ifid_hold       = 1'b0;
      ifid_flush      = 1'b0;
      idexe_flush     = 1'b0;
      if (w_freeze) begin
         // A memory stall suspends everything, including a flush in progress.
         pc_hold   = 1'b1;
         ifid_hold = 1'b1;
      end else begin
         case (r_state)
            RUN: begin
               if (exe_branch_taken) begin
                  ifid_flush  = 1'b1;
                  idexe_flush = 1'b1;
                  if (FLUSH_CYCLES > 1) begin
                     w_state_nxt     = BR_FLUSH;
                     w_flush_cnt_nxt = FLUSH_LD;
                  end
               end else if (w_lu) begin
                  pc_hold     = 1'b1;
                  ifid_hold   = 1'b1;
                  idexe_flush = 1'b1;
               end
            end
            BR_FLUSH: begin
               // EXE holds a bubble here, so a branch indication is meaningless and ignored.
               ifid_flush      = 1'b1;
               idexe_flush     = 1'b1;
               w_flush_cnt_nxt = r_flush_cnt - 3'd1;
               if (r_flush_cnt == 3'd1) w_state_nxt = RUN;
            end
            default: w_state_nxt = RUN;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state       <= RUN;
         r_flush_cnt   <= 3'd0;
         r_cycle_cnt   <= '0;
         r_instret_cnt <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_flush_cnt <= w_flush_cnt_nxt;
         r_cycle_cnt <= r_cycle_cnt + CNT_ONE;
         if (wb_valid && !w_freeze) r_instret_cnt <= r_instret_cnt + CNT_ONE;
      end
   end

   assign cycle_cnt   = r_cycle_cnt;
   assign instret_cnt = r_instret_cnt;

`ifdef HAZARD_PERF_EN
   logic        w_lu_stall, w_br_event;
   logic [31:0] r_lu_stall_cnt, r_br_flush_cnt;

   assign w_lu_stall = !w_freeze && (r_state == RUN) && !exe_branch_taken && w_lu;
   assign w_br_event = !w_freeze && (r_state == RUN) && exe_branch_taken;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_lu_stall_cnt <= 32'h0;
         r_br_flush_cnt <= 32'h0;
      end else begin
         if (w_lu_stall && (r_lu_stall_cnt != 32'hFFFF_FFFF)) r_lu_stall_cnt <= r_lu_stall_cnt + 32'h1;
         if (w_br_event && (r_br_flush_cnt != 32'hFFFF_FFFF)) r_br_flush_cnt <= r_br_flush_cnt + 32'h1;
      end
   end

   assign lu_stall_cnt = r_lu_stall_cnt;
   assign br_flush_cnt = r_br_flush_cnt;
`else
   assign lu_stall_cnt = 32'h0;
   assign br_flush_cnt = 32'h0;
`endif

endmodule
